// File: rtl/tty_writer_if.sv
// tty_writer_if: byte-stream handshake plus framebuffer port-b signals of the TTY writer.
//
//   tx_data  [7:0]  character byte from the console source
//   tx_valid        tx_data is valid
//   tx_ready        writer can accept a byte (transfer on tx_valid & tx_ready at clock edge)
//   addrb    [12:0] framebuffer address {row[5:0], col[6:0]}
//   dinb     [7:0]  framebuffer write data
//   web             framebuffer write enable
//   enb             framebuffer port enable
//   doutb    [7:0]  framebuffer read data, valid the cycle after an enb & ~web access
//
// Modports:
//   slave  - the writer itself (consumes bytes, drives the RAM port)
//   master - the environment (byte source and character RAM)
interface tty_writer_if;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [12:0] addrb;
    logic [7:0]  dinb;
    logic        web;
    logic        enb;
    logic [7:0]  doutb;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output addrb,
        output dinb,
        output web,
        output enb,
        input  doutb
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  addrb,
        input  dinb,
        input  web,
        input  enb,
        output doutb
    );
endinterface

// File: rtl/tty_writer.sv
// tty_writer: glass-TTY character writer for the text-mode framebuffer.
//
// Accepts bytes over a valid/ready handshake, writes printable characters at the cursor,
// handles CR/LF/BS/FF, wraps lines, and scrolls the region of ROWS rows by copying each
// row up one line and blanking the last row. After reset (and on FF) the whole 8 KB
// character RAM is filled with spaces.
//
// Parameters:
//   COLS  columns per text row (<= 128; RAM row stride is fixed at 128)
//   ROWS  rows in the scrolling region (2..64)
//
// Ports:
//   msoc_clk  clock
//   reset     asynchronous active-high reset
//   bus       tty_writer_if.slave: tx_data/tx_valid/tx_ready and addrb/dinb/web/enb/doutb
//   busy      ~tx_ready
//   cur_row   cursor row
//   cur_col   cursor column
module tty_writer #(
    parameter int unsigned COLS = 128,
    parameter int unsigned ROWS = 32
) (
    input  logic           msoc_clk,
    input  logic           reset,
    tty_writer_if.slave    bus,
    output logic           busy,
    output logic [5:0]     cur_row,
    output logic [6:0]     cur_col
);

    localparam logic [5:0] LastRow = 6'(ROWS - 1);
    localparam logic [6:0] LastCol = 7'(COLS - 1);
    localparam logic [7:0] Space   = 8'h20;

    typedef enum logic [2:0] {
        StClrAll,
        StIdle,
        StPut,
        StScrlRd,
        StScrlWr,
        StClrLine
    } state_e;

    state_e      state_q, state_d;
    // Next address to clear in StClrAll; bit 13 set means all 8192 writes are issued.
    logic [13:0] clr_cnt_q, clr_cnt_d;
    logic [5:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    // Scroll source address in StScrlRd/StScrlWr, address being blanked in StClrLine.
    logic [12:0] src_q, src_d;

    logic [12:0] addrb_q, addrb_d;
    logic [7:0]  dinb_q, dinb_d;
    logic        web_q, web_d;
    logic        enb_q, enb_d;
    logic        tx_ready_q, tx_ready_d;

    logic        row_adv;
    logic        accept;

    assign accept = bus.tx_valid & tx_ready_q;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        src_d      = src_q;
        addrb_d    = '0;
        dinb_d     = '0;
        web_d      = 1'b0;
        enb_d      = 1'b0;
        tx_ready_d = 1'b0;
        row_adv    = 1'b0;

        unique case (state_q)
            StClrAll: begin
                if (!clr_cnt_q[13]) begin
                    addrb_d   = clr_cnt_q[12:0];
                    dinb_d    = Space;
                    web_d     = 1'b1;
                    enb_d     = 1'b1;
                    clr_cnt_d = clr_cnt_q + 14'd1;
                end else begin
                    state_d    = StIdle;
                    tx_ready_d = 1'b1;
                    clr_cnt_d  = '0;
                    row_d      = '0;
                    col_d      = '0;
                end
            end

            StIdle: begin
                tx_ready_d = 1'b1;
                if (accept) begin
                    if (bus.tx_data >= 8'h20 && bus.tx_data <= 8'h7e) begin
                        // The byte is captured straight into the write-data register.
                        state_d    = StPut;
                        addrb_d    = {row_q, col_q};
                        dinb_d     = bus.tx_data;
                        web_d      = 1'b1;
                        enb_d      = 1'b1;
                        tx_ready_d = 1'b0;
                    end else begin
                        case (bus.tx_data)
                            8'h0d: col_d = '0;
                            8'h0a: row_adv = 1'b1;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d = col_q - 7'd1;
                                end
                            end
                            8'h0c: begin
                                // Start the full clear immediately with address 0.
                                state_d    = StClrAll;
                                addrb_d    = '0;
                                dinb_d     = Space;
                                web_d      = 1'b1;
                                enb_d      = 1'b1;
                                clr_cnt_d  = 14'd1;
                                tx_ready_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            StPut: begin
                if (col_q < LastCol) begin
                    col_d      = col_q + 7'd1;
                    state_d    = StIdle;
                    tx_ready_d = 1'b1;
                end else begin
                    col_d   = '0;
                    row_adv = 1'b1;
                end
            end

            StScrlRd: begin
                // doutb for src arrives next cycle, when the row above is written.
                state_d = StScrlWr;
                addrb_d = src_q - 13'd128;
                web_d   = 1'b1;
                enb_d   = 1'b1;
            end

            StScrlWr: begin
                if (src_q[6:0] == LastCol) begin
                    if (src_q[12:7] == LastRow) begin
                        state_d = StClrLine;
                        src_d   = {LastRow, 7'd0};
                        addrb_d = {LastRow, 7'd0};
                        dinb_d  = Space;
                        web_d   = 1'b1;
                        enb_d   = 1'b1;
                    end else begin
                        state_d = StScrlRd;
                        src_d   = {src_q[12:7] + 6'd1, 7'd0};
                        addrb_d = {src_q[12:7] + 6'd1, 7'd0};
                        enb_d   = 1'b1;
                    end
                end else begin
                    state_d = StScrlRd;
                    src_d   = src_q + 13'd1;
                    addrb_d = src_q + 13'd1;
                    enb_d   = 1'b1;
                end
            end

            StClrLine: begin
                if (src_q[6:0] == LastCol) begin
                    state_d    = StIdle;
                    tx_ready_d = 1'b1;
                end else begin
                    src_d   = src_q + 13'd1;
                    addrb_d = src_q + 13'd1;
                    dinb_d  = Space;
                    web_d   = 1'b1;
                    enb_d   = 1'b1;
                end
            end

            default: begin
                state_d   = StClrAll;
                clr_cnt_d = '0;
            end
        endcase

        // Shared by LF in StIdle and by line wrap out of StPut.
        if (row_adv) begin
            if (row_q < LastRow) begin
                row_d      = row_q + 6'd1;
                state_d    = StIdle;
                tx_ready_d = 1'b1;
            end else begin
                // Scrolling always leaves the cursor at the start of the blank last row.
                state_d    = StScrlRd;
                col_d      = '0;
                src_d      = {6'd1, 7'd0};
                addrb_d    = {6'd1, 7'd0};
                dinb_d     = '0;
                web_d      = 1'b0;
                enb_d      = 1'b1;
                tx_ready_d = 1'b0;
            end
        end
    end

    always_ff @(posedge msoc_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StClrAll;
            clr_cnt_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            src_q      <= '0;
            addrb_q    <= '0;
            dinb_q     <= '0;
            web_q      <= 1'b0;
            enb_q      <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            src_q      <= src_d;
            addrb_q    <= addrb_d;
            dinb_q     <= dinb_d;
            web_q      <= web_d;
            enb_q      <= enb_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign bus.addrb    = addrb_q;
    // Scroll copies pass the read data straight through to avoid an extra pipeline stage.
    assign bus.dinb     = (state_q == StScrlWr) ? bus.doutb : dinb_q;
    assign bus.web      = web_q;
    assign bus.enb      = enb_q;
    assign bus.tx_ready = tx_ready_q;
    assign busy         = ~tx_ready_q;
    assign cur_row      = row_q;
    assign cur_col      = col_q;

endmodule
